// File: rtl/mul_pkg.sv
// Shared types and widths for the radix-8 Booth multiplier datapath.
// Widths are fixed for the 8x8 configuration (12-bit partial products, 18-bit accumulator).
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions within a digit's one-hot magnitude select (bit k selects k*A)
  localparam int MAG_0 = 0;
  localparam int MAG_1 = 1;
  localparam int MAG_2 = 2;
  localparam int MAG_3 = 3;
  localparam int MAG_4 = 4;

  localparam int SEL_W = 5;
  localparam int PP_W  = 12;
  localparam int ACC_W = 18;

  function automatic logic isOneHot(input logic [SEL_W-1:0] s);
    return (s != '0) && ((s & (s - SEL_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-8 Booth partial product: selects 0/A/2A/3A/4A and applies the digit sign.
// A malformed select yields a zero contribution and raises illegal.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH+1:0] a3,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  neg,
  output logic signed [PP_W-1:0] pp,
  output logic                  illegal
);

  localparam int MAG_W = PP_W - 1;

  logic [MAG_W-1:0] mag;

  always_comb begin
    illegal = !isOneHot(sel);
    mag     = '0;
    if (!illegal) begin
      if (sel[MAG_0]) mag = '0;
      if (sel[MAG_1]) mag = MAG_W'(a);
      if (sel[MAG_2]) mag = MAG_W'({a, 1'b0});
      if (sel[MAG_3]) mag = MAG_W'(a3);
      if (sel[MAG_4]) mag = MAG_W'({a, 2'b00});
    end
    // Negating a zero magnitude stays zero, so a "-0" digit is harmless
    pp = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/booth_pp_accum.sv
// Iterative radix-8 Booth accumulator: accept in IDLE, one digit per cycle, product valid 3 cycles after accept.
// Product and error hold in DONE until iReady; no new input is taken until the block returns to IDLE.
module booth_pp_accum
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                iValid,
  output logic                                oReady,
  input  logic [DATA_WIDTH-1:0]               iA,
  input  logic [NUM_DIGITS-1:0][SEL_W-1:0]    iBoothSel,
  input  logic [NUM_DIGITS-1:0]               iNeg,
  output logic                                oValid,
  input  logic                                iReady,
  output logic [2*DATA_WIDTH-1:0]             oProd,
  output logic                                oErr
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_t state, stateNext;

  logic [IDX_W-1:0]              idx;
  logic [DATA_WIDTH-1:0]         aQ;
  logic [DATA_WIDTH+1:0]         a3Q;
  logic [NUM_DIGITS-1:0][SEL_W-1:0] selQ;
  logic [NUM_DIGITS-1:0]         negQ;
  logic signed [ACC_W-1:0]       accQ;
  logic                          errQ;

  logic signed [PP_W-1:0]        ppDigit;
  logic                          illegal;
  logic signed [ACC_W-1:0]       ppExt;
  logic signed [ACC_W-1:0]       ppShift;
  logic signed [ACC_W-1:0]       accNext;
  logic                          lastDigit;

  booth_pp_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uPpGen (
    .a      (aQ),
    .a3     (a3Q),
    .sel    (selQ[idx]),
    .neg    (negQ[idx]),
    .pp     (ppDigit),
    .illegal(illegal)
  );

  // Digit idx carries weight 8^idx
  always_comb begin
    ppExt     = {{(ACC_W-PP_W){ppDigit[PP_W-1]}}, ppDigit};
    ppShift   = ppExt <<< (3 * idx);
    accNext   = accQ + ppShift;
    lastDigit = (idx == IDX_W'(NUM_DIGITS - 1));
  end

  assign oReady = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iValid)    stateNext = ACC;
      ACC:     if (lastDigit) stateNext = DONE;
      DONE:    if (iReady)    stateNext = IDLE;
      default:                stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      aQ     <= '0;
      a3Q    <= '0;
      selQ   <= '0;
      negQ   <= '0;
      accQ   <= '0;
      errQ   <= 1'b0;
      oValid <= 1'b0;
      oProd  <= '0;
      oErr   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iValid) begin
            aQ   <= iA;
            a3Q  <= (DATA_WIDTH+2)'(iA) + (DATA_WIDTH+2)'({iA, 1'b0});
            selQ <= iBoothSel;
            negQ <= iNeg;
            accQ <= '0;
            idx  <= '0;
            errQ <= 1'b0;
          end
        end
        ACC: begin
          accQ <= accNext;
          idx  <= idx + IDX_W'(1);
          errQ <= errQ | illegal;
          if (lastDigit) begin
            oValid <= 1'b1;
            oProd  <= accNext[2*DATA_WIDTH-1:0];
            oErr   <= errQ | illegal;
          end
        end
        DONE: begin
          if (iReady) oValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Directed bench for booth_pp_accum: hand-computed products, latency, error flag, backpressure and mid-flight reset.
module tb_booth_pp_accum;

  logic            clk = 1'b0;
  logic            rst;
  logic            iValid;
  logic            oReady;
  logic [7:0]      iA;
  logic [2:0][4:0] iBoothSel;
  logic [2:0]      iNeg;
  logic            oValid;
  logic            iReady;
  logic [15:0]     oProd;
  logic            oErr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_pp_accum dut (
    .clk      (clk),
    .rst      (rst),
    .iValid   (iValid),
    .oReady   (oReady),
    .iA       (iA),
    .iBoothSel(iBoothSel),
    .iNeg     (iNeg),
    .oValid   (oValid),
    .iReady   (iReady),
    .oProd    (oProd),
    .oErr     (oErr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents one transaction in IDLE, then scrambles the inputs right after the accept edge
  task automatic sendTxn(input logic [7:0] a, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] ng);
    chk("rdy_idle", 32'(oReady), 32'd1);
    iA        = a;
    iBoothSel = {s2, s1, s0};
    iNeg      = ng;
    iValid    = 1'b1;
    @(posedge clk); #1;
    iValid    = 1'b0;
    iA        = ~a;
    iBoothSel = {s0, s2, s1};
    iNeg      = ~ng;
  endtask

  task automatic waitDone(input string tag, input logic [15:0] expProd, input logic expErr);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c < 3) chk({tag, "_vld_early"}, 32'(oValid), 32'd0);
    end
    chk({tag, "_vld"},  32'(oValid), 32'd1);
    chk({tag, "_prod"}, 32'(oProd),  32'(expProd));
    chk({tag, "_err"},  32'(oErr),   32'(expErr));
    chk({tag, "_rdy"},  32'(oReady), 32'd0);
  endtask

  task automatic handshake(input string tag);
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;
    chk({tag, "_hs_vld"}, 32'(oValid), 32'd0);
    chk({tag, "_hs_rdy"}, 32'(oReady), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    iValid    = 1'b0;
    iA        = '0;
    iBoothSel = '0;
    iNeg      = '0;
    iReady    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdy",  32'(oReady), 32'd1);
    chk("rst_vld",  32'(oValid), 32'd0);
    chk("rst_prod", 32'(oProd),  32'd0);
    chk("rst_err",  32'(oErr),   32'd0);

    // 255 * 255 with B encoded as (-1, 0, +4): -255 + 1020*64 = 65025
    sendTxn(8'hFF, 5'b00010, 5'b00001, 5'b10000, 3'b001);
    waitDone("ff_ff", 16'hFE01, 1'b0);
    handshake("ff_ff");

    // 0x5A * 3 through the registered 3A path: 270
    sendTxn(8'h5A, 5'b01000, 5'b00001, 5'b00001, 3'b000);
    waitDone("x5a_3", 16'h010E, 1'b0);
    handshake("x5a_3");

    // -0 in digit 0, +2 in digit 1 (weight 8): 128 * 16 = 2048
    sendTxn(8'h80, 5'b00001, 5'b00100, 5'b00001, 3'b001);
    waitDone("negzero", 16'h0800, 1'b0);
    handshake("negzero");

    // Illegal select in digit 1 contributes nothing and flags the error
    sendTxn(8'h07, 5'b00010, 5'b00011, 5'b00001, 3'b000);
    waitDone("illegal", 16'h0007, 1'b1);
    handshake("illegal");

    // Error flag must not leak into the following legal transaction
    sendTxn(8'h5A, 5'b01000, 5'b00001, 5'b00001, 3'b000);
    waitDone("after_err", 16'h010E, 1'b0);
    handshake("after_err");

    // Backpressure: outputs frozen while iReady stays low and inputs churn
    sendTxn(8'h07, 5'b00010, 5'b00011, 5'b00001, 3'b000);
    waitDone("bp", 16'h0007, 1'b1);
    for (int i = 0; i < 10; i++) begin
      iValid    = i[0];
      iA        = 8'(i * 37);
      iBoothSel = {3{5'b00010}};
      iNeg      = 3'(i);
      @(posedge clk); #1;
      chk("bp_hold_prod", 32'(oProd),  32'h0007);
      chk("bp_hold_err",  32'(oErr),   32'd1);
      chk("bp_hold_vld",  32'(oValid), 32'd1);
      chk("bp_hold_rdy",  32'(oReady), 32'd0);
    end
    iValid = 1'b0;
    handshake("bp");
    @(posedge clk); #1;
    chk("bp_no_accept", 32'(oReady), 32'd1);

    // Reset during the second accumulate cycle discards the transaction
    sendTxn(8'hFF, 5'b00010, 5'b00001, 5'b10000, 3'b001);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_rdy",  32'(oReady), 32'd1);
    chk("midrst_vld",  32'(oValid), 32'd0);
    chk("midrst_prod", 32'(oProd),  32'd0);
    chk("midrst_err",  32'(oErr),   32'd0);

    sendTxn(8'hFF, 5'b00010, 5'b00001, 5'b10000, 3'b001);
    waitDone("post_rst", 16'hFE01, 1'b0);
    handshake("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
